riscv_multicycle_ctrl: RTL and testbench

- Parametrised multicycle RISC-V (RV32I plus optional M) control unit.
- Generates all datapath control strobes from a 4-bit state register.
- Adds three things over the basic multicycle controller: variable-latency memory handshake, multi-cycle MUL/DIV stall, and an illegal-opcode trap state.
- Also maintains a retired-instruction counter. Sits between the instruction register and the multicycle datapath.

---
 rtl/riscv_multicycle_ctrl_pkg.sv | 81 ++++++++
 rtl/riscv_instret_counter.sv | 39 +++
 rtl/riscv_multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_ctrl_pkg
// Description : Shared encodings for the multicycle RISC-V controller and its
//               datapath: FSM states, base opcodes and mux-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_multicycle_ctrl_pkg;

   // FSM state encodings (also exported on oState for debug)
   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_EXE_MEM = 4'd2;
   localparam logic [3:0] ST_EXE_R   = 4'd3;
   localparam logic [3:0] ST_EXE_I   = 4'd4;
   localparam logic [3:0] ST_BRANCH  = 4'd5;
   localparam logic [3:0] ST_JAL     = 4'd6;
   localparam logic [3:0] ST_JALR    = 4'd7;
   localparam logic [3:0] ST_LUI     = 4'd8;
   localparam logic [3:0] ST_AUIPC   = 4'd9;
   localparam logic [3:0] ST_MEM_LD  = 4'd10;
   localparam logic [3:0] ST_MEM_ST  = 4'd11;
   localparam logic [3:0] ST_WB_ALU  = 4'd12;
   localparam logic [3:0] ST_WB_LD   = 4'd13;
   localparam logic [3:0] ST_MULDIV  = 4'd14;
   localparam logic [3:0] ST_TRAP    = 4'd15;

   // RV32I base opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Register write-back source
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
   localparam logic [1:0] M2R_IMM    = 2'b11;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_RDEC = 2'b10;
   localparam logic [1:0] ALUOP_IDEC = 2'b11;

   // ALU operand A / B selects
   localparam logic [1:0] ORIGA_PC     = 2'b00;
   localparam logic [1:0] ORIGA_RS1    = 2'b01;
   localparam logic [1:0] ORIGA_PCBACK = 2'b10;
   localparam logic [1:0] ORIGB_RS2    = 2'b00;
   localparam logic [1:0] ORIGB_FOUR   = 2'b01;
   localparam logic [1:0] ORIGB_IMM    = 2'b10;

   // PC source
   localparam logic ORIGPC_ALU    = 1'b0;
   localparam logic ORIGPC_ALUOUT = 1'b1;

   // First execute state for an opcode seen in DECODE; unknown opcodes trap.
   function automatic logic [3:0] decode_dispatch(input logic [6:0] opcode);
      logic [3:0] st;
      case (opcode)
         OP_LOAD, OP_STORE: st = ST_EXE_MEM;
         OP_R:              st = ST_EXE_R;
         OP_I:              st = ST_EXE_I;
         OP_BRANCH:         st = ST_BRANCH;
         OP_JAL:            st = ST_JAL;
         OP_JALR:           st = ST_JALR;
         OP_LUI:            st = ST_LUI;
         OP_AUIPC:          st = ST_AUIPC;
         default:           st = ST_TRAP;
      endcase
      return st;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_instret_counter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_instret_counter
// Description : Retired-instruction counter; wraps modulo 2^CNT_W, async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_instret_counter #(
   parameter int CNT_W = 32
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iEn,
   output logic [CNT_W-1:0] oCount
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Advance by one on each retire; natural overflow gives the wrap.
   always_comb begin
      count_d = count_q;
      if (iEn) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign oCount = count_q;

endmodule
`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_ctrl
// Description : Multicycle RV32I(+M) control unit with memory handshake,
//               MUL/DIV stall, illegal-opcode trap and instret counter.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_multicycle_ctrl
   import riscv_multicycle_ctrl_pkg::*;
#(
   parameter int ENABLE_MULDIV    = 1,
   parameter int ENABLE_HANDSHAKE = 1,
   parameter int CNT_W            = 32
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [6:0]       iOpcode,
   input  logic             iFunct7b0,
   input  logic             iMemReady,
   input  logic             iMulDivDone,
   output logic             oIRWrite,
   output logic             oPCWrite,
   output logic             oPCWriteCond,
   output logic             oIorD,
   output logic             oMemRead,
   output logic             oMemWrite,
   output logic             oRegWrite,
   output logic [1:0]       oMem2Reg,
   output logic [1:0]       oALUOp,
   output logic [1:0]       oOrigAALU,
   output logic [1:0]       oOrigBALU,
   output logic             oOrigPC,
   output logic             oMulDivStart,
   output logic             oTrap,
   output logic [3:0]       oState,
   output logic [CNT_W-1:0] oInstret
);

   localparam logic MULDIV_EN = (ENABLE_MULDIV != 0);

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       ready_w;
   logic       retire_w;

   generate
      if (ENABLE_HANDSHAKE != 0) begin : g_handshake
         assign ready_w = iMemReady;
      end else begin : g_no_handshake
         assign ready_w = 1'b1;
      end
   endgenerate

   // Next-state logic: memory states wait on ready, MULDIV waits on done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:   if (ready_w) state_d = ST_DECODE;
         ST_DECODE:  state_d = decode_dispatch(iOpcode);
         ST_EXE_MEM: state_d = (iOpcode == OP_LOAD) ? ST_MEM_LD : ST_MEM_ST;
         ST_EXE_R: begin
            if (iFunct7b0) state_d = MULDIV_EN ? ST_MULDIV : ST_TRAP;
            else           state_d = ST_WB_ALU;
         end
         ST_EXE_I:   state_d = ST_WB_ALU;
         ST_MULDIV:  if (iMulDivDone) state_d = ST_WB_ALU;
         ST_MEM_LD:  if (ready_w) state_d = ST_WB_LD;
         ST_MEM_ST:  if (ready_w) state_d = ST_FETCH;
         ST_TRAP:    state_d = ST_TRAP;
         default:    state_d = ST_FETCH;   // single-cycle completion states
      endcase
   end

   // State register; reset abandons any pending wait immediately.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore strobe decode; fetch writes and store write are gated by ready.
   always_comb begin
      oIRWrite     = 1'b0;
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oIorD        = 1'b0;
      oMemRead     = 1'b0;
      oMemWrite    = 1'b0;
      oRegWrite    = 1'b0;
      oMem2Reg     = M2R_ALUOUT;
      oALUOp       = ALUOP_ADD;
      oOrigAALU    = ORIGA_PC;
      oOrigBALU    = ORIGB_RS2;
      oOrigPC      = ORIGPC_ALU;
      oMulDivStart = 1'b0;
      oTrap        = 1'b0;
      case (state_q)
         ST_FETCH: begin
            oMemRead  = 1'b1;
            oOrigBALU = ORIGB_FOUR;
            // PC/IR must not capture while reset is still held
            oIRWrite  = ready_w & ~iRST;
            oPCWrite  = ready_w & ~iRST;
         end
         ST_DECODE: begin
            oOrigAALU = ORIGA_PCBACK;
            oOrigBALU = ORIGB_IMM;
         end
         ST_EXE_MEM: begin
            oOrigAALU = ORIGA_RS1;
            oOrigBALU = ORIGB_IMM;
         end
         ST_EXE_R: begin
            oOrigAALU    = ORIGA_RS1;
            oALUOp       = ALUOP_RDEC;
            // EXE_R lasts one cycle, so this is a single-cycle pulse
            oMulDivStart = iFunct7b0 & MULDIV_EN;
         end
         ST_EXE_I: begin
            oOrigAALU = ORIGA_RS1;
            oOrigBALU = ORIGB_IMM;
            oALUOp    = ALUOP_IDEC;
         end
         ST_BRANCH: begin
            oOrigAALU    = ORIGA_RS1;
            oALUOp       = ALUOP_SUB;
            oPCWriteCond = 1'b1;
            oOrigPC      = ORIGPC_ALUOUT;
         end
         ST_JAL: begin
            oRegWrite = 1'b1;
            oMem2Reg  = M2R_PC;
            oPCWrite  = 1'b1;
            oOrigPC   = ORIGPC_ALUOUT;
         end
         ST_JALR: begin
            oOrigAALU = ORIGA_RS1;
            oOrigBALU = ORIGB_IMM;
            oPCWrite  = 1'b1;
            oRegWrite = 1'b1;
            oMem2Reg  = M2R_PC;
         end
         ST_LUI: begin
            oRegWrite = 1'b1;
            oMem2Reg  = M2R_IMM;
         end
         ST_AUIPC:  oRegWrite = 1'b1;
         ST_MEM_LD: begin
            oMemRead = 1'b1;
            oIorD    = 1'b1;
         end
         ST_MEM_ST: begin
            oIorD     = 1'b1;
            oMemWrite = ready_w;
         end
         ST_WB_ALU: oRegWrite = 1'b1;
         ST_WB_LD: begin
            oRegWrite = 1'b1;
            oMem2Reg  = M2R_MDR;
         end
         ST_TRAP:   oTrap = 1'b1;
         default: ;
      endcase
   end

   // An instruction retires when it leaves an execute/write-back state for FETCH.
   assign retire_w = (state_d == ST_FETCH) && (state_q != ST_FETCH) &&
                     (state_q != ST_DECODE) && (state_q != ST_TRAP);

   riscv_instret_counter #(
      .CNT_W (CNT_W)
   ) u_instret (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iEn    (retire_w),
      .oCount (oInstret)
   );

   assign oState = state_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_multicycle_ctrl
// Description : Self-checking bench for riscv_multicycle_ctrl (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_ctrl;

   localparam logic [3:0] S_FET = 4'd0,  S_DEC = 4'd1,  S_EXM = 4'd2,  S_EXR = 4'd3;
   localparam logic [3:0] S_EXI = 4'd4,  S_BR  = 4'd5,  S_JAL = 4'd6,  S_JLR = 4'd7;
   localparam logic [3:0] S_LUI = 4'd8,  S_AUI = 4'd9,  S_MLD = 4'd10, S_MST = 4'd11;
   localparam logic [3:0] S_WBA = 4'd12, S_WBL = 4'd13, S_MD  = 4'd14, S_TRP = 4'd15;

   localparam logic [6:0] O_LD = 7'b0000011, O_ST = 7'b0100011, O_R = 7'b0110011;
   localparam logic [6:0] O_I = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
   localparam logic [6:0] O_JLR = 7'b1100111, O_LUI = 7'b0110111, O_AUI = 7'b0010111;
   localparam logic [6:0] O_SYS = 7'b1110011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, f7, rdy, mdd;
   logic [6:0]  op;
   // ctl layout: IRW PCW PCWC IorD MRd MWr RegW M2R[2] ALUOp[2] A[2] B[2] OrigPC MDStart Trap
   logic [17:0] ctl_a, ctl_b, ctl_c;
   logic [3:0]  st_a, st_b, st_c;
   logic [31:0] in_a, in_c;
   logic [3:0]  in_b;

   // a: default config, b: no MUL/DIV with 4-bit counter, c: handshake disabled
   riscv_multicycle_ctrl dut_a (
      .iCLK(clk), .iRST(rst), .iOpcode(op), .iFunct7b0(f7), .iMemReady(rdy), .iMulDivDone(mdd),
      .oIRWrite(ctl_a[17]), .oPCWrite(ctl_a[16]), .oPCWriteCond(ctl_a[15]), .oIorD(ctl_a[14]),
      .oMemRead(ctl_a[13]), .oMemWrite(ctl_a[12]), .oRegWrite(ctl_a[11]), .oMem2Reg(ctl_a[10:9]),
      .oALUOp(ctl_a[8:7]), .oOrigAALU(ctl_a[6:5]), .oOrigBALU(ctl_a[4:3]), .oOrigPC(ctl_a[2]),
      .oMulDivStart(ctl_a[1]), .oTrap(ctl_a[0]), .oState(st_a), .oInstret(in_a));

   riscv_multicycle_ctrl #(.ENABLE_MULDIV(0), .CNT_W(4)) dut_b (
      .iCLK(clk), .iRST(rst), .iOpcode(op), .iFunct7b0(f7), .iMemReady(rdy), .iMulDivDone(mdd),
      .oIRWrite(ctl_b[17]), .oPCWrite(ctl_b[16]), .oPCWriteCond(ctl_b[15]), .oIorD(ctl_b[14]),
      .oMemRead(ctl_b[13]), .oMemWrite(ctl_b[12]), .oRegWrite(ctl_b[11]), .oMem2Reg(ctl_b[10:9]),
      .oALUOp(ctl_b[8:7]), .oOrigAALU(ctl_b[6:5]), .oOrigBALU(ctl_b[4:3]), .oOrigPC(ctl_b[2]),
      .oMulDivStart(ctl_b[1]), .oTrap(ctl_b[0]), .oState(st_b), .oInstret(in_b));

   riscv_multicycle_ctrl #(.ENABLE_HANDSHAKE(0)) dut_c (
      .iCLK(clk), .iRST(rst), .iOpcode(op), .iFunct7b0(f7), .iMemReady(rdy), .iMulDivDone(mdd),
      .oIRWrite(ctl_c[17]), .oPCWrite(ctl_c[16]), .oPCWriteCond(ctl_c[15]), .oIorD(ctl_c[14]),
      .oMemRead(ctl_c[13]), .oMemWrite(ctl_c[12]), .oRegWrite(ctl_c[11]), .oMem2Reg(ctl_c[10:9]),
      .oALUOp(ctl_c[8:7]), .oOrigAALU(ctl_c[6:5]), .oOrigBALU(ctl_c[4:3]), .oOrigPC(ctl_c[2]),
      .oMulDivStart(ctl_c[1]), .oTrap(ctl_c[0]), .oState(st_c), .oInstret(in_c));

   typedef struct {
      logic [6:0] op; logic f7; logic rdy; logic mdd; logic [3:0] st; int inst;
   } vec_t;
   typedef struct {
      int which; logic [3:0] st; logic [17:0] ctl; int inst;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   int    passed = 0;
   int    total  = 0;
   string tag = "init";

   // Reference strobe table taken straight from the state descriptions.
   function automatic logic [17:0] exp_ctl(input logic [3:0] s, input logic r, input logic f,
                                           input logic md_en, input logic in_rst);
      logic [17:0] c;
      c = '0;
      case (s)
         S_FET: begin c[13] = 1'b1; c[4:3] = 2'b01; c[17] = r & ~in_rst; c[16] = r & ~in_rst; end
         S_DEC: begin c[6:5] = 2'b10; c[4:3] = 2'b10; end
         S_EXM: begin c[6:5] = 2'b01; c[4:3] = 2'b10; end
         S_EXR: begin c[6:5] = 2'b01; c[8:7] = 2'b10; c[1] = f & md_en; end
         S_EXI: begin c[6:5] = 2'b01; c[4:3] = 2'b10; c[8:7] = 2'b11; end
         S_BR:  begin c[6:5] = 2'b01; c[8:7] = 2'b01; c[15] = 1'b1; c[2] = 1'b1; end
         S_JAL: begin c[11] = 1'b1; c[10:9] = 2'b10; c[16] = 1'b1; c[2] = 1'b1; end
         S_JLR: begin c[6:5] = 2'b01; c[4:3] = 2'b10; c[16] = 1'b1; c[11] = 1'b1; c[10:9] = 2'b10; end
         S_LUI: begin c[11] = 1'b1; c[10:9] = 2'b11; end
         S_AUI: c[11] = 1'b1;
         S_MLD: begin c[13] = 1'b1; c[14] = 1'b1; end
         S_MST: begin c[14] = 1'b1; c[12] = r; end
         S_WBA: c[11] = 1'b1;
         S_WBL: begin c[11] = 1'b1; c[10:9] = 2'b01; end
         S_TRP: c[0] = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   task automatic check(input string what, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s %s: actual %0d required %0d", tag, what, act, exp);
   endtask

   // Queue the expectation for the current inputs, let logic settle, then compare.
   task automatic check_now(input int which, input logic [3:0] est, input int einst);
      exp_t e;
      logic [3:0]  a_st;
      logic [17:0] a_ctl;
      int          a_in;
      e.which = which;
      e.st    = est;
      e.ctl   = exp_ctl(est, (which == 2) ? 1'b1 : rdy, f7, (which != 1), rst);
      e.inst  = einst;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      case (e.which)
         1:       begin a_st = st_b; a_ctl = ctl_b; a_in = int'(in_b); end
         2:       begin a_st = st_c; a_ctl = ctl_c; a_in = int'(in_c); end
         default: begin a_st = st_a; a_ctl = ctl_a; a_in = int'(in_a); end
      endcase
      check("state", int'(a_st), int'(e.st));
      if (a_ctl !== e.ctl)
         $display("FAIL %s ctl: actual %b required %b", tag, a_ctl, e.ctl);
      total++;
      if (a_ctl === e.ctl) passed++;
      check("instret", a_in, e.inst);
   endtask

   // One clock cycle: drive at the falling edge, check, move to the next falling edge.
   task automatic cyc(input int which, input logic [6:0] o, input logic f, input logic r,
                      input logic m, input logic [3:0] est, input int einst);
      op = o; f7 = f; rdy = r; mdd = m;
      check_now(which, est, einst);
      @(negedge clk);
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic do_reset(input int which);
      rst = 1'b1; rdy = 1'b1; mdd = 1'b1;
      check_now(which, S_FET, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic void add(input logic [6:0] o, input logic f, input logic r,
                               input logic m, input logic [3:0] s, input int n);
      vec_t v;
      v.op = o; v.f7 = f; v.rdy = r; v.mdd = m; v.st = s; v.inst = n;
      vecs.push_back(v);
   endfunction

   initial begin
      rst = 1'b1; op = '0; f7 = 1'b0; rdy = 1'b0; mdd = 1'b0;

      // Instruction mix for the default configuration
      add(O_R, 0, 1, 0, S_FET, 0); add(O_R, 0, 1, 0, S_DEC, 0);
      add(O_R, 0, 1, 0, S_EXR, 0); add(O_R, 0, 1, 0, S_WBA, 0);
      for (int i = 0; i < 3; i++) add(O_LD, 0, 0, 0, S_FET, 1);
      add(O_LD, 0, 1, 0, S_FET, 1); add(O_LD, 0, 0, 0, S_DEC, 1);
      add(O_LD, 0, 0, 0, S_EXM, 1);
      add(O_LD, 0, 0, 0, S_MLD, 1); add(O_LD, 0, 0, 0, S_MLD, 1);
      add(O_LD, 0, 1, 0, S_MLD, 1); add(O_LD, 0, 1, 0, S_WBL, 1);
      add(O_LUI, 0, 1, 0, S_FET, 2); add(O_LUI, 0, 1, 1, S_DEC, 2); add(O_LUI, 0, 1, 0, S_LUI, 2);
      add(O_AUI, 0, 1, 0, S_FET, 3); add(O_AUI, 0, 1, 0, S_DEC, 3); add(O_AUI, 0, 1, 0, S_AUI, 3);
      add(O_JAL, 0, 1, 0, S_FET, 4); add(O_JAL, 0, 1, 1, S_DEC, 4); add(O_JAL, 0, 0, 0, S_JAL, 4);
      add(O_JLR, 0, 1, 0, S_FET, 5); add(O_JLR, 0, 1, 0, S_DEC, 5); add(O_JLR, 0, 1, 0, S_JLR, 5);
      add(O_BR, 0, 1, 0, S_FET, 6); add(O_BR, 0, 1, 0, S_DEC, 6); add(O_BR, 0, 1, 0, S_BR, 6);
      add(O_I, 1, 1, 0, S_FET, 7); add(O_I, 1, 1, 0, S_DEC, 7);
      add(O_I, 1, 1, 0, S_EXI, 7); add(O_I, 1, 1, 0, S_WBA, 7);
      add(O_ST, 0, 1, 0, S_FET, 8); add(O_ST, 0, 1, 0, S_DEC, 8);
      add(O_ST, 0, 1, 0, S_EXM, 8); add(O_ST, 0, 1, 0, S_MST, 8);
      add(O_SYS, 0, 1, 0, S_FET, 9);

      @(negedge clk);
      tag = "reset_a";
      do_reset(0);

      tag = "table";
      foreach (vecs[i]) cyc(0, vecs[i].op, vecs[i].f7, vecs[i].rdy, vecs[i].mdd, vecs[i].st, vecs[i].inst);

      // Illegal opcode: trap is absorbing, counter frozen, reset clears both
      tag = "trap_ill";
      cyc(0, O_SYS, 0, 1, 0, S_DEC, 9);
      for (int i = 0; i < 20; i++) cyc(0, O_SYS, i[0], 1, i[1], S_TRP, 9);
      tag = "trap_rst";
      do_reset(0);

      // MUL with start pulse and five stall cycles
      tag = "mul_a";
      cyc(0, O_R, 1, 1, 0, S_FET, 0); cyc(0, O_R, 1, 1, 0, S_DEC, 0);
      cyc(0, O_R, 1, 1, 0, S_EXR, 0);
      for (int i = 0; i < 4; i++) cyc(0, O_R, 1, 1, 0, S_MD, 0);
      cyc(0, O_R, 1, 1, 1, S_MD, 0);
      cyc(0, O_R, 1, 1, 0, S_WBA, 0);
      cyc(0, O_ST, 0, 1, 0, S_FET, 1);

      // Store waiting on memory, aborted by reset before it completes
      tag = "sw_rst";
      cyc(0, O_ST, 0, 0, 0, S_DEC, 1); cyc(0, O_ST, 0, 0, 0, S_EXM, 1);
      cyc(0, O_ST, 0, 0, 0, S_MST, 1); cyc(0, O_ST, 0, 0, 0, S_MST, 1);
      do_reset(0);

      // MUL without M support traps and does not retire
      tag = "mul_b";
      do_reset(1);
      cyc(1, O_R, 1, 1, 0, S_FET, 0); cyc(1, O_R, 1, 1, 0, S_DEC, 0);
      cyc(1, O_R, 1, 1, 0, S_EXR, 0);
      for (int i = 0; i < 3; i++) cyc(1, O_R, 1, 1, 1, S_TRP, 0);
      do_reset(1);

      // Sixteen LUIs wrap a 4-bit counter back to zero
      tag = "wrap_b";
      for (int i = 0; i < 16; i++) begin
         cyc(1, O_LUI, 0, 1, 0, S_FET, i);
         cyc(1, O_LUI, 0, 1, 0, S_DEC, i);
         cyc(1, O_LUI, 0, 1, 0, S_LUI, i);
      end
      cyc(1, O_LUI, 0, 1, 0, S_FET, 0);

      // Handshake disabled: low ready never stalls fetch or load
      tag = "nohs_c";
      do_reset(2);
      cyc(2, O_LD, 0, 0, 0, S_FET, 0); cyc(2, O_LD, 0, 0, 0, S_DEC, 0);
      cyc(2, O_LD, 0, 0, 0, S_EXM, 0); cyc(2, O_LD, 0, 0, 0, S_MLD, 0);
      cyc(2, O_LD, 0, 0, 0, S_WBL, 0); cyc(2, O_LD, 0, 0, 0, S_FET, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
